// File: rtl/list_enabled_item_id_rr.sv
// ============================================================================
// Module      : list_enabled_item_id_rr
// Description : Registered multi-grant round-robin picker. Scans the request
//               vector from a rotating pointer, emits up to GRANT_NUM item
//               ids per transfer behind a valid/ready output register, and
//               advances the pointer past the last granted item.
//               Optional macro LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN adds a
//               direct pointer load port (ptr_load / ptr_load_value).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module list_enabled_item_id_rr #(
    parameter int ITEM_NUM  = 8,
    parameter int GRANT_NUM = 4,
    localparam int ID_WIDTH  = $clog2(ITEM_NUM),
    localparam int CNT_WIDTH = $clog2(GRANT_NUM + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ITEM_NUM-1:0]           req,
    input  logic                          out_ready,
`ifdef LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN
    input  logic                          ptr_load,
    input  logic [ID_WIDTH-1:0]           ptr_load_value,
`endif
    output logic                          out_valid,
    output logic [GRANT_NUM*ID_WIDTH-1:0] grant_id,
    output logic [GRANT_NUM-1:0]          grant_valid,
    output logic [CNT_WIDTH-1:0]          grant_count,
    output logic [ITEM_NUM-1:0]           grant_mask
);

    localparam logic [CNT_WIDTH-1:0] c_grant_num = CNT_WIDTH'(GRANT_NUM);

    // Reject configurations the rotation arithmetic cannot support
    generate
        if ((ITEM_NUM < 2) || ((ITEM_NUM & (ITEM_NUM - 1)) != 0)) begin : g_bad_item_num
            $error("ITEM_NUM must be a power of two and at least 2");
        end
        if ((GRANT_NUM < 1) || (GRANT_NUM > ITEM_NUM)) begin : g_bad_grant_num
            $error("GRANT_NUM must satisfy 1 <= GRANT_NUM <= ITEM_NUM");
        end
    endgenerate

    logic                          r_out_valid;
    logic [GRANT_NUM*ID_WIDTH-1:0] r_grant_id;
    logic [GRANT_NUM-1:0]          r_grant_valid;
    logic [CNT_WIDTH-1:0]          r_grant_count;
    logic [ITEM_NUM-1:0]           r_grant_mask;
    logic [ID_WIDTH-1:0]           r_ptr;

    logic                          w_load;
    logic [ITEM_NUM-1:0]           w_eff_req;
    logic [GRANT_NUM*ID_WIDTH-1:0] w_sel_id;
    logic [GRANT_NUM-1:0]          w_sel_valid;
    logic [CNT_WIDTH-1:0]          w_sel_cnt;
    logic [ITEM_NUM-1:0]           w_sel_mask;
    logic [ID_WIDTH-1:0]           w_sel_last;
    logic [ID_WIDTH-1:0]           w_idx;
    logic [ID_WIDTH-1:0]           w_ptr_nxt;

    // Items still sitting in a valid output are hidden so an accepting edge
    // cannot grant them a second time before upstream drops the request.
    assign w_load    = !r_out_valid || out_ready;
    assign w_eff_req = req & ~(r_out_valid ? r_grant_mask : '0);

    // Walk items in rotation order from the pointer, filling slots in order
    always_comb begin
        w_sel_id    = '0;
        w_sel_valid = '0;
        w_sel_cnt   = '0;
        w_sel_mask  = '0;
        w_sel_last  = '0;
        w_idx       = '0;
        for (int j = 0; j < ITEM_NUM; j++) begin
            w_idx = r_ptr + ID_WIDTH'(j);
            if (w_eff_req[w_idx] && (w_sel_cnt < c_grant_num)) begin
                for (int k = 0; k < GRANT_NUM; k++) begin
                    if (w_sel_cnt == CNT_WIDTH'(k)) begin
                        w_sel_id[k*ID_WIDTH +: ID_WIDTH] = w_idx;
                        w_sel_valid[k]                   = 1'b1;
                    end
                end
                w_sel_mask[w_idx] = 1'b1;
                w_sel_last        = w_idx;
                w_sel_cnt         = w_sel_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Next pointer: explicit load beats grant-driven advance; empty loads hold
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_load && (w_sel_cnt != '0)) begin
            w_ptr_nxt = w_sel_last + ID_WIDTH'(1);
        end
`ifdef LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN
        if (ptr_load) begin
            w_ptr_nxt = ptr_load_value;
        end
`endif
    end

    // Output register and pointer; flush clears both, stall holds both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_grant_id    <= '0;
            r_grant_valid <= '0;
            r_grant_count <= '0;
            r_grant_mask  <= '0;
            r_ptr         <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
            r_grant_id    <= '0;
            r_grant_valid <= '0;
            r_grant_count <= '0;
            r_grant_mask  <= '0;
            r_ptr         <= '0;
        end else begin
            if (w_load) begin
                r_out_valid   <= (w_sel_cnt != '0);
                r_grant_id    <= w_sel_id;
                r_grant_valid <= w_sel_valid;
                r_grant_count <= w_sel_cnt;
                r_grant_mask  <= w_sel_mask;
            end
            r_ptr <= w_ptr_nxt;
        end
    end

    assign out_valid   = r_out_valid;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign grant_count = r_grant_count;
    assign grant_mask  = r_grant_mask;

endmodule

`default_nettype wire

// File: tb/tb_list_enabled_item_id_rr.sv
// ============================================================================
// Module      : tb_list_enabled_item_id_rr
// Description : Scoreboard bench for list_enabled_item_id_rr (ITEM_NUM=8,
//               GRANT_NUM=4) driven by hand-computed directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_list_enabled_item_id_rr;

    localparam int ITEM_NUM  = 8;
    localparam int GRANT_NUM = 4;
    localparam int ID_WIDTH  = 3;
    localparam int CNT_WIDTH = 3;

    typedef struct packed {
        logic                          valid;
        logic [GRANT_NUM*ID_WIDTH-1:0] ids;
        logic [GRANT_NUM-1:0]          gv;
        logic [CNT_WIDTH-1:0]          cnt;
        logic [ITEM_NUM-1:0]           mask;
        logic [ID_WIDTH-1:0]           ptr;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          flush = 1'b0;
    logic [ITEM_NUM-1:0]           req = '0;
    logic                          out_ready = 1'b0;
`ifdef LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN
    logic                          ptr_load = 1'b0;
    logic [ID_WIDTH-1:0]           ptr_load_value = '0;
`endif
    logic                          out_valid;
    logic [GRANT_NUM*ID_WIDTH-1:0] grant_id;
    logic [GRANT_NUM-1:0]          grant_valid;
    logic [CNT_WIDTH-1:0]          grant_count;
    logic [ITEM_NUM-1:0]           grant_mask;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    list_enabled_item_id_rr #(
        .ITEM_NUM  (ITEM_NUM),
        .GRANT_NUM (GRANT_NUM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req            (req),
        .out_ready      (out_ready),
`ifdef LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN
        .ptr_load       (ptr_load),
        .ptr_load_value (ptr_load_value),
`endif
        .out_valid      (out_valid),
        .grant_id       (grant_id),
        .grant_valid    (grant_valid),
        .grant_count    (grant_count),
        .grant_mask     (grant_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [GRANT_NUM*ID_WIDTH-1:0] pk(input logic [2:0] a, input logic [2:0] b,
                                                         input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    // Drive one cycle of stimulus and queue the state expected after its edge
    task automatic step(input logic [7:0] r, input logic rdy, input logic fl,
                        input logic v, input logic [11:0] ids, input logic [3:0] gv,
                        input logic [2:0] cnt, input logic [7:0] m, input logic [2:0] p);
        exp_t e;
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        flush     = fl;
        e.valid = v; e.ids = ids; e.gv = gv; e.cnt = cnt; e.mask = m; e.ptr = p;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: compare the registered outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("out_valid",   32'(out_valid),   32'(e.valid));
                chk("grant_id",    32'(grant_id),    32'(e.ids));
                chk("grant_valid", 32'(grant_valid), 32'(e.gv));
                chk("grant_count", 32'(grant_count), 32'(e.cnt));
                chk("grant_mask",  32'(grant_mask),  32'(e.mask));
                chk("ptr",         32'(dut.r_ptr),   32'(e.ptr));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid",   32'(out_valid),   0);
        chk("rst grant_id",    32'(grant_id),    0);
        chk("rst grant_valid", 32'(grant_valid), 0);
        chk("rst grant_count", 32'(grant_count), 0);
        chk("rst grant_mask",  32'(grant_mask),  0);
        chk("rst ptr",         32'(dut.r_ptr),   0);
        @(negedge clk);
        rst = 1'b0;

        // Basic grant, empty, partial, wrap
        step(8'hA6, 1, 0, 1, pk(1,2,5,7), 4'hF, 4, 8'hA6, 0);
        step(8'h00, 1, 0, 0, '0,          4'h0, 0, 8'h00, 0);
        step(8'h20, 1, 0, 1, pk(5,0,0,0), 4'h1, 1, 8'h20, 6);
        step(8'hC3, 1, 0, 1, pk(6,7,0,1), 4'hF, 4, 8'hC3, 2);
        // Double-grant masking on held requests
        step(8'h03, 1, 0, 0, '0,          4'h0, 0, 8'h00, 2);
        step(8'h03, 1, 0, 1, pk(0,1,0,0), 4'h3, 2, 8'h03, 2);
        step(8'h03, 1, 0, 0, '0,          4'h0, 0, 8'h00, 2);
        step(8'h03, 1, 0, 1, pk(0,1,0,0), 4'h3, 2, 8'h03, 2);
        step(8'h00, 1, 0, 0, '0,          4'h0, 0, 8'h00, 2);
        // Flush wins over load and resets the pointer
        step(8'hFF, 1, 1, 0, '0,          4'h0, 0, 8'h00, 0);
        // Full request, then stall under random requests
        step(8'hFF, 1, 0, 1, pk(0,1,2,3), 4'hF, 4, 8'h0F, 4);
        for (int i = 0; i < 5; i++) begin
            step(8'($urandom), 0, 0, 1, pk(0,1,2,3), 4'hF, 4, 8'h0F, 4);
        end
        step(8'hFF, 1, 0, 1, pk(4,5,6,7), 4'hF, 4, 8'hF0, 0);
        step(8'hFF, 1, 0, 1, pk(0,1,2,3), 4'hF, 4, 8'h0F, 4);
        step(8'hFF, 1, 0, 1, pk(4,5,6,7), 4'hF, 4, 8'hF0, 0);
        // Flush while stalled
        step(8'h0C, 1, 0, 1, pk(2,3,0,0), 4'h3, 2, 8'h0C, 4);
        step(8'hFF, 0, 0, 1, pk(2,3,0,0), 4'h3, 2, 8'h0C, 4);
        step(8'hFF, 0, 1, 0, '0,          4'h0, 0, 8'h00, 0);
        step(8'h30, 1, 0, 1, pk(4,5,0,0), 4'h3, 2, 8'h30, 6);
        step(8'hFF, 0, 0, 1, pk(4,5,0,0), 4'h3, 2, 8'h30, 6);

        // Asynchronous reset between edges while stalled
        #3;
        rst = 1'b1;
        #1;
        chk("arst out_valid",   32'(out_valid),   0);
        chk("arst grant_id",    32'(grant_id),    0);
        chk("arst grant_valid", 32'(grant_valid), 0);
        chk("arst grant_count", 32'(grant_count), 0);
        chk("arst grant_mask",  32'(grant_mask),  0);
        chk("arst ptr",         32'(dut.r_ptr),   0);
        rst = 1'b0;

        // Wrap-around scan and pointer wrap after reset
        step(8'h81, 1, 0, 1, pk(0,7,0,0), 4'h3, 2, 8'h81, 0);
        step(8'hC0, 1, 0, 1, pk(6,0,0,0), 4'h1, 1, 8'h40, 7);
        step(8'h81, 1, 0, 1, pk(7,0,0,0), 4'h3, 2, 8'h81, 1);
        step(8'hFE, 1, 0, 1, pk(1,2,3,4), 4'hF, 4, 8'h1E, 5);
        step(8'h00, 1, 0, 0, '0,          4'h0, 0, 8'h00, 5);

        @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/list_enabled_item_id_rr.md
Name: list_enabled_item_id_rr

Overview:
Registered multi-grant round-robin picker. Each load cycle it scans request vector `req` from an internal rotating pointer and emits up to GRANT_NUM enabled item ids in rotation order. Output sits in one register stage with a valid/ready handshake. The pointer advances past the last granted item, which gives fair selection for issue/wakeup/commit-style selection logic.

Parameters:
ITEM_NUM, 8, number of request items; power of two, >= 2
GRANT_NUM, 4, max ids emitted per transfer; 1 <= GRANT_NUM <= ITEM_NUM
ID_WIDTH, $clog2(ITEM_NUM), derived, not overridden
CNT_WIDTH, $clog2(GRANT_NUM + 1), derived, not overridden

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of output register and pointer
req  input  ITEM_NUM  request bitmask; bit i = item i enabled
out_ready  input  1  downstream accepts current output
out_valid  output  1  output register holds >= 1 grant
grant_id  output  ID_WIDTH x GRANT_NUM  granted ids; slot 0 = first in rotation order
grant_valid  output  GRANT_NUM  per-slot valid; always a contiguous run from slot 0
grant_count  output  CNT_WIDTH  number of valid slots
grant_mask  output  ITEM_NUM  bitmask of ids in the output register

Behaviour:
- Reset (async, rst=1): out_valid=0, all grant_id=0, grant_valid=0, grant_count=0, grant_mask=0, ptr=0. Takes effect immediately, including mid-stall.
- Selection (combinational):
  - eff_req = req & ~(out_valid ? grant_mask : 0). Masking prevents a double grant when upstream clears the requests at the same edge the grant is accepted.
  - Scan order is ptr, ptr+1 .. ITEM_NUM-1, then 0 .. ptr-1.
  - The first min(popcount(eff_req), GRANT_NUM) set items fill slots 0.. in scan order.
  - Unused slots: id=0, valid=0.
- Load condition: load = !out_valid | out_ready. flush has priority over load.
- On load:
  - Output register captures the selection.
  - out_valid <= (sel_count != 0).
  - If sel_count != 0, ptr <= (last granted id + 1) mod ITEM_NUM; otherwise ptr is unchanged.
- Stall (out_valid & !out_ready): all outputs and ptr hold, regardless of req.
- flush=1: next edge sets out_valid=0, grant_valid=0, grant_count=0, grant_mask=0, grant_id=0, ptr=0. Any pending output is discarded.
- Latency: req to grant output is 1 cycle. Throughput is one transfer per cycle while out_ready=1.
- Empty: req=0 on load gives out_valid=0 and ptr unchanged.
- Full: req all-ones gives GRANT_NUM grants and ptr += GRANT_NUM mod ITEM_NUM.
- Wrap: scan crosses ITEM_NUM-1 -> 0 seamlessly; pointer arithmetic is mod ITEM_NUM (natural ID_WIDTH overflow).
- Invariant: grant_count == popcount(grant_valid) == popcount(grant_mask); ids within one transfer are distinct.
- Elaboration error if GRANT_NUM > ITEM_NUM or ITEM_NUM is not a power of two.

Optional Feature:
Macro: LIST_ENABLED_ITEM_ID_RR_PTR_LOAD_EN
- Defined: adds inputs ptr_load (1) and ptr_load_value (ID_WIDTH).
  - ptr_load=1 sets ptr <= ptr_load_value at the next edge.
  - Priority: flush > ptr_load > load-driven advance. The output register still loads normally that cycle.
  - The loaded value applies to the following cycle's selection.
- Undefined: ports absent; ptr changes only via reset, flush and grants.

Test Plan:
1. Basic grant: ITEM_NUM=8, GRANT_NUM=4, reset, req=8'b10100110, out_ready=1 -> next cycle ids {1,2,5,7}, grant_valid=4'b1111, grant_count=4, grant_mask=8'hA6; ptr becomes 0.
2. Partial and wrap: req=8'h20 -> id[0]=5, grant_valid=4'b0001, count=1, ptr=6. Next req=8'b11000011 -> ids {6,7,0,1}, count=4, ptr=2.
3. Double-grant mask: req=8'h03 held, out_ready=1 -> cycle1 ids {0,1}; cycle2 out_valid=0 (masked); cycle3 ids {0,1} again.
4. Stall: out_valid=1 with ids {0,1,2,3}, out_ready=0 for 5 cycles while req is randomised -> outputs and ptr unchanged. Release out_ready -> new selection from ptr=4.
5. Flush/reset mid-operation:
   - Stalled out_valid=1, flush=1 -> next cycle out_valid=0, ptr=0.
   - Repeat with async rst pulse between edges -> outputs 0 immediately.
6. Random: 65536 cycles of random req/out_ready vs. reference model -> ids, mask, count and ptr match every accepted transfer. With the macro defined, random ptr_load is added and checked for the same match.
